// File: rtl/uart_8250_pkg.sv
// Shared types and constants for the 8250 UART receive path.
// UART_RX_PARITY_EN adds the PARITY state to the rx FSM encoding.
package uart_8250_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    , RX_PARITY  = 3'd5
`endif
  } rx_state_t;

  localparam int LSR_DR = 0;
  localparam int LSR_OE = 1;
  localparam int LSR_PE = 2;
  localparam int LSR_FE = 3;
  localparam int LSR_BI = 4;

  localparam int LCR_WLS = 0;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;

  function automatic int unsigned trig_level(input logic [1:0] sel);
    unique case (sel)
      2'd0: return 1;
      2'd1: return 4;
      2'd2: return 8;
      default: return 14;
    endcase
  endfunction

endpackage

// File: rtl/uart_8250_rx_fifo.sv
// Receive FIFO: show-ahead read, flush, level, overrun detect.
// Pointers carry one wrap bit above the address.
module uart_8250_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       rdata,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [LVL_W-1:0] wp_q, rp_q;
  logic             do_push, do_pop;

  assign level   = wp_q - rp_q;
  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~pop & ~flush;
  assign rdata   = mem[rp_q[AW-1:0]];

  always_ff @(posedge CLK_I) begin
    if (RST_I || flush) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (do_push && !flush) mem[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_8250_rx.sv
// 8250 UART receive path: synchroniser, bit timer, frame FSM, FIFO.
// Define UART_RX_PARITY_EN to build parity checking.
module uart_8250_rx
  import uart_8250_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             RX_I,
  input  logic [15:0]      DIV_I,
  input  logic [7:0]       LCR_I,
  input  logic [1:0]       RX_TRIG_I,
  input  logic             RX_FLUSH_I,
  input  logic             RX_POP_I,
  input  logic             LSR_CLR_I,
  output logic [7:0]       RX_DATA_O,
  output logic             RX_DR_O,
  output logic             RX_OE_O,
  output logic             RX_PE_O,
  output logic             RX_FE_O,
  output logic             RX_BI_O,
  output logic             RX_TRIG_O,
  output logic [LVL_W-1:0] RX_LEVEL_O
);

  logic        rx_s1, rx_s2, rx_d;
  rx_state_t   state_q, state_n;
  logic [16:0] cnt_q, cnt_n, half, bitl;
  logic [2:0]  idx_q, idx_n, last;
  logic [7:0]  shr_q, shr_n, head;
  logic        par_q, par_n, expire;
  logic        push, pe_ev, fe_ev, bi_ev, ovf;
  logic        oe_q, pe_q, fe_q, bi_q;
  logic        empty, full;
  logic [4:0]  lsr;
  logic [31:0] thr;
  logic [LVL_W-1:0] level;
  logic        unused_lcr;

`ifdef UART_RX_PARITY_EN
  assign unused_lcr = ^{LCR_I[7:5], LCR_I[LCR_STB]};
`else
  assign unused_lcr = ^{LCR_I[7:2]};
`endif

  assign half   = (DIV_I == '0) ? 17'd1 : {1'b0, DIV_I};
  assign bitl   = half << 1;
  assign expire = (cnt_q == '0);
  assign last   = 3'd4 + {1'b0, LCR_I[LCR_WLS+1:LCR_WLS]};

  always_comb begin
    state_n = state_q;
    cnt_n   = expire ? cnt_q : cnt_q - 17'd1;
    idx_n   = idx_q;
    shr_n   = shr_q;
    par_n   = par_q;
    push    = 1'b0;
    pe_ev   = 1'b0;
    fe_ev   = 1'b0;
    bi_ev   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_d && !rx_s2) begin
          cnt_n   = half - 17'd1;
          state_n = RX_START;
        end
      end
      RX_START: begin
        if (expire) begin
          if (!rx_s2) begin
            cnt_n   = bitl - 17'd1;
            idx_n   = '0;
            shr_n   = '0;
            par_n   = 1'b0;
            state_n = RX_DATA;
          end else begin
            state_n = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (expire) begin
          shr_n[idx_q] = rx_s2;
          cnt_n = bitl - 17'd1;
          idx_n = idx_q + 3'd1;
          if (idx_q == last) begin
`ifdef UART_RX_PARITY_EN
            state_n = LCR_I[LCR_PEN] ? RX_PARITY : RX_STOP;
`else
            state_n = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (expire) begin
          par_n   = rx_s2;
          cnt_n   = bitl - 17'd1;
          state_n = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (expire) begin
          push  = 1'b1;
          fe_ev = ~rx_s2;
          bi_ev = ~rx_s2 & (shr_q == '0) & ~par_q;
`ifdef UART_RX_PARITY_EN
          // EPS=1: parity bit equals XOR of data (even total)
          pe_ev = LCR_I[LCR_PEN] &
                  (par_q != (LCR_I[LCR_EPS] ? ^shr_q : ~^shr_q));
`endif
          state_n = bi_ev ? RX_WAIT_HIGH : RX_IDLE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_d    <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shr_q   <= '0;
      par_q   <= 1'b0;
      oe_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
    end else begin
      rx_s1   <= RX_I;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2;
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shr_q   <= shr_n;
      par_q   <= par_n;
      oe_q    <= ovf   | (oe_q & ~LSR_CLR_I);
      pe_q    <= pe_ev | (pe_q & ~LSR_CLR_I);
      fe_q    <= fe_ev | (fe_q & ~LSR_CLR_I);
      bi_q    <= bi_ev | (bi_q & ~LSR_CLR_I);
    end
  end

  uart_8250_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (push),
    .wdata (shr_q),
    .pop   (RX_POP_I),
    .flush (RX_FLUSH_I),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .ovf   (ovf),
    .level (level)
  );

  always_comb begin
    lsr         = '0;
    lsr[LSR_DR] = ~empty;
    lsr[LSR_OE] = oe_q;
    lsr[LSR_PE] = pe_q;
    lsr[LSR_FE] = fe_q;
    lsr[LSR_BI] = bi_q;
    thr = trig_level(RX_TRIG_I);
    if (thr > FIFO_DEPTH) thr = FIFO_DEPTH;
  end

  assign RX_DR_O    = lsr[LSR_DR];
  assign RX_OE_O    = lsr[LSR_OE];
  assign RX_PE_O    = lsr[LSR_PE];
  assign RX_FE_O    = lsr[LSR_FE];
  assign RX_BI_O    = lsr[LSR_BI];
  assign RX_DATA_O  = empty ? 8'h00 : head;
  assign RX_LEVEL_O = level;
  assign RX_TRIG_O  = (32'(level) >= thr) & ~full | full;

endmodule

// File: tb/tb_uart_8250_rx.sv
// Scoreboard bench for uart_8250_rx: directed frames, queue-based monitor.
// Expected PE follows UART_RX_PARITY_EN.
module tb_uart_8250_rx;

  localparam int LVL_W = 5;
`ifdef UART_RX_PARITY_EN
  localparam logic PE_EXP = 1'b1;
`else
  localparam logic PE_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             RST_I, RX_I, RX_FLUSH_I, RX_POP_I, LSR_CLR_I;
  logic [15:0]      DIV_I;
  logic [7:0]       LCR_I;
  logic [1:0]       RX_TRIG_I;
  logic [7:0]       RX_DATA_O;
  logic             RX_DR_O, RX_OE_O, RX_PE_O, RX_FE_O, RX_BI_O, RX_TRIG_O;
  logic [LVL_W-1:0] RX_LEVEL_O;

  logic [7:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_8250_rx dut (
    .CLK_I      (clk),
    .RST_I      (RST_I),
    .RX_I       (RX_I),
    .DIV_I      (DIV_I),
    .LCR_I      (LCR_I),
    .RX_TRIG_I  (RX_TRIG_I),
    .RX_FLUSH_I (RX_FLUSH_I),
    .RX_POP_I   (RX_POP_I),
    .LSR_CLR_I  (LSR_CLR_I),
    .RX_DATA_O  (RX_DATA_O),
    .RX_DR_O    (RX_DR_O),
    .RX_OE_O    (RX_OE_O),
    .RX_PE_O    (RX_PE_O),
    .RX_FE_O    (RX_FE_O),
    .RX_BI_O    (RX_BI_O),
    .RX_TRIG_O  (RX_TRIG_O),
    .RX_LEVEL_O (RX_LEVEL_O)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops and compares every character the DUT presents.
  initial begin
    logic [7:0] e;
    RX_POP_I = 1'b0;
    forever begin
      @(negedge clk);
      if (RX_POP_I) begin
        RX_POP_I = 1'b0;
      end else if (mon_en && RX_DR_O) begin
        n_cmp++;
        n_pop++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL rx_unexpected: got %0h expected none", RX_DATA_O);
        end else begin
          e = sb.pop_front();
          if (RX_DATA_O !== e) begin
            n_err++;
            $display("FAIL rx_data: got %0h expected %0h", RX_DATA_O, e);
          end
        end
        RX_POP_I = 1'b1;
      end
    end
  end

  task automatic bit_out(input logic v);
    RX_I = v;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb,
                            input bit has_par, input logic pbit,
                            input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < nb; i++) bit_out(d[i]);
    if (has_par) bit_out(pbit);
    bit_out(stop);
    RX_I = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !RX_DR_O && !RX_POP_I) break;
      @(negedge clk);
    end
    chk(name, {31'd0, sb.size() == 0 && !RX_DR_O}, 32'd1);
  endtask

  task automatic pulse_clr();
    LSR_CLR_I = 1'b1;
    @(negedge clk);
    LSR_CLR_I = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    RST_I = 1'b1; RX_I = 1'b1; DIV_I = 16'd4; LCR_I = 8'h03;
    RX_TRIG_I = 2'd0; RX_FLUSH_I = 1'b0; LSR_CLR_I = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dr", RX_DR_O, 0);
    chk("rst_level", RX_LEVEL_O, 0);
    chk("rst_flags", {RX_OE_O, RX_PE_O, RX_FE_O, RX_BI_O}, 0);
    chk("rst_trig", RX_TRIG_O, 0);
    chk("rst_data", RX_DATA_O, 0);
    RST_I = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0x55
    sb.push_back(8'h55);
    send_frame(8'h55, 8, 0, 0, 1);
    chk("t1_dr", RX_DR_O, 1);
    chk("t1_data", RX_DATA_O, 8'h55);
    chk("t1_level", RX_LEVEL_O, 1);
    chk("t1_flags", {RX_OE_O, RX_PE_O, RX_FE_O, RX_BI_O}, 0);
    mon_en = 1'b1;
    wait_drain("t1_drain");
    chk("t1_dr_after_pop", RX_DR_O, 0);

    // start glitch then valid frame
    RX_I = 1'b0;
    repeat (3) @(negedge clk);
    RX_I = 1'b1;
    repeat (16) @(negedge clk);
    chk("t2_no_push", RX_LEVEL_O, 0);
    sb.push_back(8'hA3);
    send_frame(8'hA3, 8, 0, 0, 1);
    wait_drain("t2_drain");

    // 8E1 with wrong parity
    LCR_I = 8'h1B;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 8, 1, 1, 1);
    wait_drain("t3_drain");
    chk("t3_pe", RX_PE_O, PE_EXP);
    chk("t3_fe", RX_FE_O, 0);
    pulse_clr();
    chk("t3_pe_clr", RX_PE_O, 0);

    // framing error, then 5-bit word
    LCR_I = 8'h03;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 8, 0, 0, 0);
    wait_drain("t4_drain");
    chk("t4_fe", RX_FE_O, 1);
    chk("t4_bi", RX_BI_O, 0);
    pulse_clr();
    LCR_I = 8'h00;
    sb.push_back(8'h1F);
    send_frame(8'h1F, 5, 0, 0, 1);
    wait_drain("t4_5bit_drain");
    chk("t4_fe_clr", RX_FE_O, 0);

    // break: 12 bit times low
    LCR_I = 8'h03;
    p0 = n_pop;
    sb.push_back(8'h00);
    RX_I = 1'b0;
    repeat (96) @(negedge clk);
    chk("t5_bi", RX_BI_O, 1);
    chk("t5_fe", RX_FE_O, 1);
    chk("t5_one_push", n_pop - p0, 1);
    RX_I = 1'b1;
    repeat (8) @(negedge clk);
    pulse_clr();
    sb.push_back(8'h41);
    send_frame(8'h41, 8, 0, 0, 1);
    wait_drain("t5_drain");
    chk("t5_bi_after", RX_BI_O, 0);

    // fill, overrun, flush
    mon_en = 1'b0;
    RX_TRIG_I = 2'd3;
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 8, 0, 0, 1);
      if (i == 12) chk("t6_trig_13", RX_TRIG_O, 0);
      if (i == 13) chk("t6_trig_14", RX_TRIG_O, 1);
    end
    chk("t6_level_full", RX_LEVEL_O, 16);
    chk("t6_oe_before", RX_OE_O, 0);
    send_frame(8'h77, 8, 0, 0, 1);
    chk("t6_level_ovr", RX_LEVEL_O, 16);
    chk("t6_oe", RX_OE_O, 1);
    chk("t6_head", RX_DATA_O, 8'h00);
    chk("t6_trig", RX_TRIG_O, 1);
    RX_FLUSH_I = 1'b1;
    @(negedge clk);
    RX_FLUSH_I = 1'b0;
    chk("t6_flush_level", RX_LEVEL_O, 0);
    chk("t6_flush_dr", RX_DR_O, 0);
    chk("t6_flush_oe", RX_OE_O, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
